// File: rtl/delay_meter_pkg.sv
// Shared types and helpers for the delay_meter block.
// Holds the FSM state encoding and a "more than one bit set" test used on the match mask.
package delay_meter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      MEASURE,
      DONE
   } dm_state_t;

   // Widest mask the helper accepts; callers zero-extend to this width.
   localparam int POP_W = 256;

   // Clearing the lowest set bit leaves a nonzero value only if a second bit was set.
   function automatic logic popcount_gt1(input logic [POP_W-1:0] v);
      return (v & (v - POP_W'(1))) != '0;
   endfunction

endpackage

// File: rtl/first_set_encoder.sv
// Combinational lowest-set-bit encoder with an any-bit-set flag.
// The index is 0 when no bit is set.
module first_set_encoder #(
   parameter int N = 16,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      any = |vec;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/delay_meter.sv
// Measures the cycle latency between a reference stream and its delayed copy by
// AND-ing per-candidate match bits over a fixed window of enabled cycles.
module delay_meter
   import delay_meter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_DELAY = 16,
   parameter int WINDOW    = 64,
   localparam int DW       = $clog2(MAX_DELAY)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [WIDTH-1:0] ref_in,
   input  logic [WIDTH-1:0] dly_in,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             locked,
   output logic             ambiguous,
   output logic [DW-1:0]    delay
);

   localparam int CNT_MAX = (MAX_DELAY > WINDOW) ? MAX_DELAY : WINDOW;
   localparam int CW      = $clog2(CNT_MAX + 1);

   dm_state_t            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [MAX_DELAY-1:0] mask_q, mask_d;
   logic [MAX_DELAY-1:0] match;
   logic [MAX_DELAY-1:0] mask_next;
   logic [WIDTH-1:0]     hist_q [MAX_DELAY-1];
   logic [WIDTH-1:0]     hist_d [MAX_DELAY-1];
   logic                 locked_q, locked_d;
   logic                 ambiguous_q, ambiguous_d;
   logic [DW-1:0]        delay_q, delay_d;
   logic [DW-1:0]        enc_idx;
   logic                 enc_any;

   // The history keeps shifting in every state so it is already primed when a measurement starts.
   always_comb begin
      hist_d = hist_q;
      if (ena) begin
         hist_d[0] = ref_in;
         for (int i = 1; i < MAX_DELAY - 1; i++) begin
            hist_d[i] = hist_q[i-1];
         end
      end
   end

   always_comb begin
      match    = '0;
      match[0] = (dly_in == ref_in);
      for (int k = 1; k < MAX_DELAY; k++) begin
         match[k] = (dly_in == hist_q[k-1]);
      end
   end

   assign mask_next = mask_q & match;

   // Encoding the post-AND mask lets results land on the same edge that enters DONE.
   first_set_encoder #(
      .N (MAX_DELAY)
   ) u_enc (
      .vec (mask_next),
      .idx (enc_idx),
      .any (enc_any)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mask_d      = mask_q;
      locked_d    = locked_q;
      ambiguous_d = ambiguous_q;
      delay_d     = delay_q;
      unique case (state_q)
         IDLE: begin
            if (ena && start) begin
               state_d = FILL;
               cnt_d   = '0;
            end
         end
         FILL: begin
            if (ena) begin
               if (cnt_q == CW'(MAX_DELAY - 1)) begin
                  state_d = MEASURE;
                  cnt_d   = '0;
                  mask_d  = '1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         MEASURE: begin
            if (ena) begin
               mask_d = mask_next;
               if (cnt_q == CW'(WINDOW - 1)) begin
                  state_d     = DONE;
                  locked_d    = enc_any;
                  ambiguous_d = popcount_gt1(POP_W'(mask_next));
                  delay_d     = enc_idx;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mask_q      <= '0;
         locked_q    <= 1'b0;
         ambiguous_q <= 1'b0;
         delay_q     <= '0;
         for (int i = 0; i < MAX_DELAY - 1; i++) begin
            hist_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mask_q      <= mask_d;
         locked_q    <= locked_d;
         ambiguous_q <= ambiguous_d;
         delay_q     <= delay_d;
         for (int i = 0; i < MAX_DELAY - 1; i++) begin
            hist_q[i] <= hist_d[i];
         end
      end
   end

   assign busy      = (state_q == FILL) || (state_q == MEASURE);
   assign done      = (state_q == DONE);
   assign locked    = locked_q;
   assign ambiguous = ambiguous_q;
   assign delay     = delay_q;

endmodule

// File: tb/tb_delay_meter.sv
// Bench for delay_meter: a table of measurement setups feeds a scoreboard of expected
// results, plus hand sequences for reset mid-measurement and start-while-busy.
module tb_delay_meter;

   localparam int PERIOD = 10;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       ena   = 1'b1;
   logic       start = 1'b0;
   logic [3:0] ref_in;
   logic [3:0] dly_in;
   logic       busy;
   logic       done;
   logic       locked;
   logic       ambiguous;
   logic [3:0] delay;

   // Stream source: mode 0 = counter through a latency-lat delay line (sel == latency),
   // mode 1 = constant 4'hA on both taps, mode 2 = counter vs an unrelated LFSR.
   int         mode       = 0;
   int         lat        = 3;
   logic       ena_toggle = 1'b0;
   logic [3:0] ref_cnt    = 4'h0;
   logic [3:0] pipe [16]  = '{default: 4'h0};
   logic [15:0] lfsr      = 16'hACE1;

   int total = 0;
   int bad   = 0;
   int done_pulses = 0;

   typedef struct {
      string      name;
      int         mode;
      int         lat;
      logic       tog;
      logic       exp_locked;
      logic       exp_amb;
      logic [3:0] exp_delay;
      int         exp_cyc;
   } vec_t;

   typedef struct {
      string      name;
      logic       lk;
      logic       amb;
      logic [3:0] dl;
      int         cyc;
      int         tol;
      time        t0;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[8];

   delay_meter #(
      .WIDTH     (4),
      .MAX_DELAY (16),
      .WINDOW    (64)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .ref_in    (ref_in),
      .dly_in    (dly_in),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .locked    (locked),
      .ambiguous (ambiguous),
      .delay     (delay)
   );

   always #(PERIOD/2) clk = ~clk;

   // The whole upstream source is clock-enabled together with the meter.
   always @(posedge clk) begin
      if (ena) begin
         ref_cnt <= ref_cnt + 4'd1;
         pipe[0] <= ref_cnt;
         for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   always_comb begin
      ref_in = (mode == 1) ? 4'hA : ref_cnt;
      case (mode)
         0:       dly_in = (lat == 0) ? ref_cnt : pipe[lat-1];
         1:       dly_in = 4'hA;
         default: dly_in = lfsr[3:0];
      endcase
   end

   always @(negedge clk) ena = ena_toggle ? ~ena : 1'b1;

   always @(negedge clk) if (done) done_pulses++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic pulse_start(output time t_edge);
      int guard;
      guard = 0;
      @(negedge clk);
      start = 1'b1;
      do begin
         @(posedge clk);
         guard++;
      end while (!ena && guard < 4);
      t_edge = $time;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      time  t;
      mode       = v.mode;
      lat        = v.lat;
      ena_toggle = v.tog;
      repeat (2) @(negedge clk);
      pulse_start(t);
      e.name = v.name;
      e.lk   = v.exp_locked;
      e.amb  = v.exp_amb;
      e.dl   = v.exp_delay;
      e.cyc  = v.exp_cyc;
      e.tol  = v.tog ? 1 : 0;
      e.t0   = t;
      sb.push_back(e);
      check({v.name, "_busy_after_start"}, busy, 1);
   endtask

   task automatic checkOutput();
      exp_t e;
      time  t_done;
      bit   seen;
      int   cyc;
      seen = 1'b0;
      t_done = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen   = 1'b1;
            t_done = $time;
         end
      end
      if (sb.size() == 0) begin
         check("scoreboard_empty", 0, 1);
         return;
      end
      e = sb.pop_front();
      check({e.name, "_done_seen"}, seen, 1);
      if (!seen) return;
      cyc = int'((t_done - e.t0 - PERIOD/2) / PERIOD);
      total++;
      if (cyc < e.cyc - e.tol || cyc > e.cyc + e.tol) begin
         bad++;
         $display("[TB] FAIL %s_latency: got %0d, expected %0d +/- %0d", e.name, cyc, e.cyc, e.tol);
      end
      check({e.name, "_locked"},    locked,    e.lk);
      check({e.name, "_ambiguous"}, ambiguous, e.amb);
      check({e.name, "_delay"},     delay,     e.dl);
      check({e.name, "_busy_in_done"}, busy, 0);
      // A start offered during the DONE cycle must not launch a measurement.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({e.name, "_start_in_done_ignored"}, busy, 0);
      check({e.name, "_results_hold"}, delay, e.dl);
   endtask

   initial begin
      time t_edge;
      int  base;

      vecs[0] = '{"lock_d3",     0, 3,  1'b0, 1'b1, 1'b0, 4'd3,  80};
      vecs[1] = '{"sweep_sel0",  0, 0,  1'b0, 1'b1, 1'b0, 4'd0,  80};
      vecs[2] = '{"sweep_sel1",  0, 1,  1'b0, 1'b1, 1'b0, 4'd1,  80};
      vecs[3] = '{"sweep_sel2",  0, 2,  1'b0, 1'b1, 1'b0, 4'd2,  80};
      vecs[4] = '{"sweep_sel3",  0, 3,  1'b0, 1'b1, 1'b0, 4'd3,  80};
      vecs[5] = '{"max_d15",     0, 15, 1'b0, 1'b1, 1'b0, 4'd15, 80};
      vecs[6] = '{"const_A",     1, 0,  1'b0, 1'b1, 1'b1, 4'd0,  80};
      vecs[7] = '{"lfsr",        2, 0,  1'b0, 1'b0, 1'b0, 4'd0,  80};

      repeat (3) @(negedge clk);
      check("reset_busy",      busy,      0);
      check("reset_done",      done,      0);
      check("reset_locked",    locked,    0);
      check("reset_ambiguous", ambiguous, 0);
      check("reset_delay",     delay,     0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("idle_busy", busy, 0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
         checkOutput();
      end

      applyStimulus('{"ena_gated", 0, 3, 1'b1, 1'b1, 1'b0, 4'd3, 160});
      checkOutput();
      ena_toggle = 1'b0;

      // Reset 40 cycles after the start edge, deep inside MEASURE.
      mode = 0;
      lat  = 3;
      repeat (4) @(negedge clk);
      pulse_start(t_edge);
      repeat (39) @(negedge clk);
      check("pre_reset_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy",      busy,      0);
      check("midrst_done",      done,      0);
      check("midrst_locked",    locked,    0);
      check("midrst_ambiguous", ambiguous, 0);
      check("midrst_delay",     delay,     0);
      base = done_pulses;
      repeat (100) @(negedge clk);
      check("midrst_no_done", done_pulses - base, 0);
      applyStimulus('{"after_reset", 0, 3, 1'b0, 1'b1, 1'b0, 4'd3, 80});
      checkOutput();

      // Second start 10 cycles into FILL must be dropped.
      repeat (4) @(negedge clk);
      base = done_pulses;
      applyStimulus('{"start_busy", 0, 2, 1'b0, 1'b1, 1'b0, 4'd2, 80});
      repeat (9) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput();
      repeat (100) @(negedge clk);
      check("start_busy_one_done", done_pulses - base, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/delay_meter.md
# delay_meter

Measures the latency, in clock cycles, between a reference data stream and a delayed copy of it. Sits directly downstream of `dynamic_delay`: `ref_in` taps the word entering the delay line and `dly_in` taps the word leaving it. On a `start` request it correlates the two streams over a fixed window and reports the matching delay, a lock flag and an ambiguity flag. Used for self-check of delay-line `sel` settings in benches and in hardware bring-up.

## Interface
- `WIDTH`, 4: width of the data words.
- `MAX_DELAY`, 16: number of candidate delays, 0..MAX_DELAY-1. Must be ≥2.
- `WINDOW`, 64: number of enabled cycles correlated per measurement. Must be ≥1.
- Local `DW` = $clog2(MAX_DELAY).

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  clock enable. When low, all state is frozen: history, counters, FSM and mask.
- `ref_in`  in  WIDTH  reference word, i.e. the delay-line input.
- `dly_in`  in  WIDTH  delayed word, i.e. the delay-line output.
- `start`  in  1  measurement request. Sampled only in IDLE with `ena`=1.
- `busy`  out  1  high during FILL and MEASURE.
- `done`  out  1  one-cycle pulse; results are updated in the same cycle.
- `locked`  out  1  at least one candidate delay matched for the entire window.
- `ambiguous`  out  1  more than one candidate delay matched.
- `delay`  out  DW  lowest matching delay. Forced to 0 when not locked.

## Operation
- History: shift register `hist[0..MAX_DELAY-2]` of WIDTH-bit words.
  - On each `ena` cycle: `hist[0]` ← `ref_in` and `hist[i]` ← `hist[i-1]`.
  - The history runs in every state, not only during a measurement.
- Taps: tap 0 = `ref_in` (combinational); tap k = `hist[k-1]` for k ≥ 1.
- Match vector: `m[k]` = (`dly_in` == tap k), computed combinationally with full-width equality.
- FSM states: IDLE, FILL, MEASURE, DONE.
  - IDLE: `start`=1 and `ena`=1 → FILL, counter cleared.
  - FILL: counts MAX_DELAY-1 enabled cycles so the history holds valid data, then → MEASURE. On that transition the mask is set to all-ones and the counter is cleared.
  - MEASURE: on each enabled cycle, mask ← mask & m. After WINDOW enabled cycles → DONE.
  - DONE: for exactly one cycle, regardless of `ena`, `done`=1, the results are registered, then → IDLE.
- Results, computed from the final mask (including the last MEASURE cycle's AND):
  - `locked` = |mask.
  - `delay` = index of the lowest set bit of the mask, or 0 if the mask is all-zero.
  - `ambiguous` = more than one bit set.
  - Results hold until the next DONE.
- `start` outside IDLE, or with `ena`=0, is ignored and not queued.
- Reset value of every output is 0. Reset also clears the history, mask, counter and FSM (to IDLE).
- Counter width is $clog2(max(MAX_DELAY, WINDOW)+1). No wrap occurs within a state.

## Timing
- Start is sampled at edge E with `ena` held high throughout:
  - `busy`=1 from E through E+MAX_DELAY+WINDOW-1.
  - `done`=1 and results valid in the cycle after edge E+MAX_DELAY+WINDOW; `busy`=0 in that cycle.
  - With default parameters, `done` follows the start edge by 80 cycles.
- Each `ena`=0 cycle during FILL or MEASURE extends the measurement by one cycle.
- Constant data at all taps yields `locked`=1, `ambiguous`=1, `delay`=0.
- Reset mid-operation takes effect on the next edge:
  - FSM goes to IDLE, `busy`=0, and the prior results are cleared.
  - No `done` pulse is issued.
- `start` asserted in the DONE cycle is ignored. The next accepted start is in IDLE, one cycle later.

## Structure
- `delay_meter_pkg` contains:
  - the FSM state enum `dm_state_t` (IDLE, FILL, MEASURE, DONE);
  - helper function `popcount_gt1`.
- Sub-module `first_set_encoder`, parameterised on `N`:
  - Combinational lowest-set-bit index, output width $clog2(N), plus an `any` output.
  - Instantiated once, on the mask.
- The top level holds the history, the compare array, the mask register, the counter and the FSM.

## Test plan
- Lock at delay 3: `ref_in` is a counter incrementing each cycle; `dly_in` is `ref_in` through 3 registers; pulse `start`. Required: `done` exactly 80 cycles after the start edge, `locked`=1, `ambiguous`=0, `delay`=3.
- Delay-line sweep: drive `dynamic_delay` with LENGTH=3, WIDTH=4, and a 4-bit counter as data.
  - Step `sel` through 0..3 and run one measurement per setting.
  - Required: reported `delay` equals the model latency of `dynamic_delay` at each `sel`, with `locked`=1. Because the counter period is 16, `ambiguous`=0.
- Ambiguous and zero cases:
  - `ref_in` = `dly_in` = 4'hA constant → `locked`=1, `ambiguous`=1, `delay`=0.
  - Unrelated LFSR on `dly_in` → `locked`=0, `delay`=0, `ambiguous`=0.
- Enable gating: same setup as the delay-3 case, with `ena` toggling 1/0 every cycle. Required: identical results; `done` at 160 cycles, give or take one, after the start edge.
- Reset mid-MEASURE: assert `rst` for one cycle 40 cycles after the start edge. Required: next cycle `busy`=0, all outputs 0, no `done` pulse. A fresh start then completes normally.
- Start while busy: pulse `start` again 10 cycles into FILL. Required: ignored, and exactly one `done` pulse at 80 cycles after the original start edge.
